// File: rtl/clk_divider_multi.sv
// clk_divider_multi: N-channel programmable clock divider.
// Each channel counts 100 MHz cycles up to its divisor and produces a registered
// half-duty slow clock plus a one-cycle tick at the start of every output period.
// New divisors are held pending and only swapped in at a period boundary (wrap,
// sync or while disabled), so an output period is never cut short or stretched.

module clk_divider_multi #(
  parameter int N_CH        = 4,
  parameter int CTR_W       = 27,
  parameter int DEFAULT_DIV = 100_000,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              incoming_CLK100MHZ,
  input  logic              reset,
  input  logic [N_CH-1:0]   enable,
  input  logic              sync,
  input  logic              div_load,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CTR_W-1:0]  div_value,
  output logic [N_CH-1:0]   outgoing_CLK,
  output logic [N_CH-1:0]   tick
);

  logic [CTR_W-1:0] ctr        [N_CH];
  logic [CTR_W-1:0] div        [N_CH];
  logic [CTR_W-1:0] pend       [N_CH];
  logic [N_CH-1:0]  pend_valid;

  logic [CTR_W-1:0] load_val;
  logic [N_CH-1:0]  load_hit;
  logic [N_CH-1:0]  at_wrap;
  logic [N_CH-1:0]  at_half;
  logic [N_CH-1:0]  take_pend;

  // Decode loads and per-channel period events; an out-of-range div_ch matches no channel
  always_comb begin
    load_val  = (div_value < CTR_W'(2)) ? CTR_W'(2) : div_value;
    load_hit  = '0;
    at_wrap   = '0;
    at_half   = '0;
    take_pend = '0;
    for (int c = 0; c < N_CH; c++) begin
      load_hit[c]  = div_load && (div_ch == CH_W'(c));
      at_wrap[c]   = (ctr[c] == div[c] - 1'b1);
      at_half[c]   = (ctr[c] == (div[c] >> 1) - 1'b1);
      take_pend[c] = pend_valid[c] && (!enable[c] || sync || at_wrap[c]);
    end
  end

  // Per-channel counter, output/tick registers and pending-divisor handoff
  always_ff @(posedge incoming_CLK100MHZ or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        ctr[c]  <= '0;
        div[c]  <= CTR_W'(DEFAULT_DIV);
        pend[c] <= CTR_W'(DEFAULT_DIV);
      end
      pend_valid   <= '0;
      outgoing_CLK <= '0;
      tick         <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (!enable[c]) begin
          ctr[c]          <= '0;
          outgoing_CLK[c] <= 1'b0;
          tick[c]         <= 1'b0;
        end else if (sync || at_wrap[c]) begin
          ctr[c]          <= '0;
          outgoing_CLK[c] <= 1'b0;
          tick[c]         <= 1'b1;
        end else if (at_half[c]) begin
          ctr[c]          <= ctr[c] + 1'b1;
          outgoing_CLK[c] <= 1'b1;
          tick[c]         <= 1'b0;
        end else begin
          ctr[c]          <= ctr[c] + 1'b1;
          tick[c]         <= 1'b0;
        end

        if (take_pend[c]) begin
          div[c] <= pend[c];
        end

        if (load_hit[c]) begin
          pend[c]       <= load_val;
          pend_valid[c] <= 1'b1;
        end else if (take_pend[c]) begin
          pend_valid[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// tb_clk_divider_multi: scoreboard bench for clk_divider_multi (N_CH=4, CTR_W=8, DEFAULT_DIV=10).
// The reference model tracks each channel as a position within its current output
// period; expected outputs are derived arithmetically from that position.

module tb_clk_divider_multi;

  localparam int N_CH = 4;
  localparam int CTR_W = 8;
  localparam int DEF_DIV = 10;

  logic             clk;
  logic             reset;
  logic [N_CH-1:0]  enable;
  logic             sync;
  logic             div_load;
  logic [1:0]       div_ch;
  logic [CTR_W-1:0] div_value;
  logic [N_CH-1:0]  outgoing_CLK;
  logic [N_CH-1:0]  tick;

  int checks = 0;
  int errors = 0;

  int m_pos  [N_CH];
  int m_div  [N_CH];
  int m_pend [N_CH];
  bit m_pv   [N_CH];
  bit m_tick [N_CH];

  logic [2*N_CH-1:0] exp_q [$];

  clk_divider_multi #(
    .N_CH(N_CH),
    .CTR_W(CTR_W),
    .DEFAULT_DIV(DEF_DIV)
  ) dut (
    .incoming_CLK100MHZ(clk),
    .reset(reset),
    .enable(enable),
    .sync(sync),
    .div_load(div_load),
    .div_ch(div_ch),
    .div_value(div_value),
    .outgoing_CLK(outgoing_CLK),
    .tick(tick)
  );

  // 100 MHz system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < N_CH; c++) begin
      m_pos[c]  = 0;
      m_div[c]  = DEF_DIV;
      m_pend[c] = DEF_DIV;
      m_pv[c]   = 1'b0;
      m_tick[c] = 1'b0;
    end
  endtask

  // Expected {outgoing_CLK, tick}: output is high for the second part of the period
  function automatic logic [2*N_CH-1:0] modelOutputs();
    logic [N_CH-1:0] o;
    logic [N_CH-1:0] t;
    for (int c = 0; c < N_CH; c++) begin
      o[c] = (m_pos[c] >= m_div[c] / 2);
      t[c] = m_tick[c];
    end
    return {o, t};
  endfunction

  // Advance the reference model by one clock edge with the given inputs
  task automatic modelStep(input logic [N_CH-1:0] en, input bit sy, input bit ld, input int ch, input int val);
    bit boundary;
    for (int c = 0; c < N_CH; c++) begin
      boundary = 1'b1;
      if (!en[c]) begin
        m_pos[c] = 0;
        m_tick[c] = 1'b0;
      end else if (sy || m_pos[c] == m_div[c] - 1) begin
        m_pos[c] = 0;
        m_tick[c] = 1'b1;
      end else begin
        m_pos[c]++;
        m_tick[c] = 1'b0;
        boundary = 1'b0;
      end
      if (boundary && m_pv[c]) begin
        m_div[c] = m_pend[c];
        m_pv[c] = 1'b0;
      end
      if (ld && ch == c) begin
        m_pend[c] = (val < 2) ? 2 : val;
        m_pv[c] = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the response expected after the next rising edge
  task automatic applyStimulus(input logic [N_CH-1:0] en, input bit sy, input bit ld,
                               input int ch, input int val, input bit rst);
    @(negedge clk);
    reset     = rst;
    enable    = en;
    sync      = sy;
    div_load  = ld;
    div_ch    = 2'(ch);
    div_value = CTR_W'(val);
    if (rst) modelReset();
    else modelStep(en, sy, ld, ch, val);
    exp_q.push_back(modelOutputs());
  endtask

  task automatic runIdle(input int n, input logic [N_CH-1:0] en);
    for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // Reset raised between clock edges must clear the outputs without waiting for a clock
  task automatic midReset();
    @(negedge clk);
    sync = 1'b0;
    div_load = 1'b0;
    #2 reset = 1'b1;
    modelReset();
    exp_q.push_back(modelOutputs());
    #1 checkOutput("async_reset", 32'({outgoing_CLK, tick}), 32'(0));
  endtask

  // Monitor: compare DUT outputs against the scoreboard shortly after each rising edge
  initial begin
    logic [2*N_CH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("cycle_outputs", 32'({outgoing_CLK, tick}), 32'(e));
      end
    end
  end

  initial begin
    reset = 1'b1;
    enable = '0;
    sync = 1'b0;
    div_load = 1'b0;
    div_ch = '0;
    div_value = '0;
    modelReset();

    $display("[TB] reset hold");
    for (int i = 0; i < 3; i++) applyStimulus(4'h0, 1'b0, 1'b0, 0, 0, 1'b1);

    $display("[TB] all channels at default divisor");
    runIdle(33, 4'hF);

    $display("[TB] ch1 load 7 mid-period");
    applyStimulus(4'hF, 1'b0, 1'b1, 1, 7, 1'b0);
    runIdle(30, 4'hF);

    $display("[TB] ch2 load 0 then 1, clamped to 2");
    applyStimulus(4'hF, 1'b0, 1'b1, 2, 0, 1'b0);
    applyStimulus(4'hF, 1'b0, 1'b1, 2, 1, 1'b0);
    runIdle(25, 4'hF);

    $display("[TB] ch3 disabled for 13 cycles");
    runIdle(13, 4'h7);
    runIdle(20, 4'hF);

    $display("[TB] sync pulse");
    runIdle(3, 4'hF);
    applyStimulus(4'hF, 1'b1, 1'b0, 0, 0, 1'b0);
    runIdle(20, 4'hF);

    $display("[TB] reset mid-period with pending load");
    applyStimulus(4'hF, 1'b0, 1'b1, 0, 5, 1'b0);
    runIdle(3, 4'hF);
    midReset();
    applyStimulus(4'hF, 1'b0, 1'b0, 0, 0, 1'b1);
    runIdle(25, 4'hF);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      logic [N_CH-1:0] en;
      en = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      applyStimulus(en, ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 20)),
                    ($urandom_range(0, 199) == 0));
    end

    @(negedge clk);
    reset = 1'b0;
    enable = 4'hF;
    sync = 1'b0;
    div_load = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("queue_drain", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
